muldiv_unit: RTL

//  Iterative multiply/divide unit for the RV32M extension.

---
 rtl/muldiv_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle, fixed DATA_WIDTH+2 cycle latency
// ports: clk, rst (sync active-high), start/op/opA/opB request (sampled when idle),
//        busy (CALC/FINISH), done (one-cycle pulse), result (held until next done)
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state;
  logic [2:0] opc;
  logic [W-1:0] a_raw, b_mag;
  logic [2*W-1:0] acc;
  logic neg_q, neg_r, div0;
  logic [CW-1:0] count;
  logic sa, sb;
  logic [W-1:0] a_abs, b_abs;
  logic [W:0] mul_sum, div_top, div_diff;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0] q_s, r_s, fin;
  assign sa = opA[W-1] & (op[2] ? !op[0] : (op == 3'b001 || op == 3'b010));
  assign sb = opB[W-1] & (op[2] ? !op[0] : (op == 3'b001));
  assign a_abs = sa ? -opA : opA;
  assign b_abs = sb ? -opB : opB;
  // multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};
  // divide: acc = {remainder, dividend bits shifting into quotient}
  assign div_top = acc[2*W-1:W-1];
  assign div_diff = div_top - {1'b0, b_mag};
  assign div_next = div_diff[W] ? {acc[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc[W-2:0], 1'b1};
  // signed overflow falls out of the magnitude path naturally; only divide-by-zero needs overriding
  assign prod = neg_q ? -acc : acc;
  assign q_s = div0 ? '1 : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
  assign r_s = div0 ? a_raw : (neg_r ? -acc[2*W-1:W] : acc[2*W-1:W]);
  assign fin = !opc[2] ? (opc[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]) : (opc[1] ? r_s : q_s);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      opc    <= '0;
      a_raw  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opc   <= op;
          a_raw <= opA;
          b_mag <= b_abs;
          acc   <= {{W{1'b0}}, a_abs};
          neg_q <= sa ^ sb;
          neg_r <= sa;
          div0  <= op[2] && opB == '0;
          count <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          acc   <= opc[2] ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(W - 1)) state <= FINISH;
        end
        FINISH: begin
          result <= fin;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
